// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button conditioner.
//
// Each channel synchronises a raw button input and filters it with a stable-time counter. It
// produces a clean level, one-cycle press/release pulses, and long-press detection.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   pb           in   N  raw asynchronous button inputs
//   pb_debounced out  N  filtered level, 1 = pressed
//   pb_rise      out  N  one-cycle pulse on a debounced press
//   pb_fall      out  N  one-cycle pulse on a debounced release
//   pb_long      out  N  one-cycle pulse when a press has been held LONG_CYCLES
//   pb_held      out  N  level, long-press reached, cleared after release
module debounce_multi #(
  parameter int unsigned N           = 4,
  parameter int unsigned CLKFREQ     = 1000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pb,
  output logic [N-1:0] pb_debounced,
  output logic [N-1:0] pb_rise,
  output logic [N-1:0] pb_fall,
  output logic [N-1:0] pb_long,
  output logic [N-1:0] pb_held
);

  localparam int unsigned DB_RAW      = DEBOUNCE_MS * CLKFREQ / 1000;
  localparam int unsigned DB_CYCLES   = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int unsigned LONG_RAW    = LONG_MS * CLKFREQ / 1000;
  localparam int unsigned LONG_CYCLES = (LONG_RAW < 1) ? 1 : LONG_RAW;

  localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
  localparam int unsigned HW = $clog2(LONG_CYCLES) + 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] LONG_SAT  = HW'(LONG_CYCLES);

  // Normalise polarity up front so everything downstream treats 1 as pressed.
  logic [N-1:0] w_pb_in;
  assign w_pb_in = ACTIVE_LOW ? ~pb : pb;

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pb_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hold;
    logic          r_deb;
    logic          r_rise;
    logic          r_fall;
    logic          r_long;
    logic          r_held;

    logic w_differs;
    logic w_qualified;
    logic w_hold_sat;
    logic w_hold_last;

    assign w_differs   = (r_sync2[g] != r_deb);
    // Synchronised input has disagreed with the output for DB_CYCLES consecutive edges.
    assign w_qualified = w_differs && (r_cnt == DB_LAST);
    assign w_hold_sat  = (r_hold == LONG_SAT);
    assign w_hold_last = (r_hold == LONG_LAST);

    // Stable-time filter: any agreement between input and output restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_deb  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= w_qualified & r_sync2[g];
        r_fall <= w_qualified & ~r_sync2[g];
        if (!w_differs) begin
          r_cnt <= '0;
        end else if (w_qualified) begin
          r_cnt <= '0;
          r_deb <= r_sync2[g];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    // Hold timer saturates at LONG_CYCLES so pb_long fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold <= '0;
        r_long <= 1'b0;
        r_held <= 1'b0;
      end else if (!r_deb) begin
        r_hold <= '0;
        r_long <= 1'b0;
        r_held <= 1'b0;
      end else if (!w_hold_sat) begin
        r_hold <= r_hold + 1'b1;
        r_long <= w_hold_last;
        if (w_hold_last) begin
          r_held <= 1'b1;
        end
      end else begin
        r_long <= 1'b0;
      end
    end

    assign pb_debounced[g] = r_deb;
    assign pb_rise[g]      = r_rise;
    assign pb_fall[g]      = r_fall;
    assign pb_long[g]      = r_long;
    assign pb_held[g]      = r_held;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: DB_CYCLES=4, LONG_CYCLES=20. Two instances, active-high (a) and
// active-low (b). Expected pulse events are queued with their due cycle when stimulus is
// driven; every negedge the due events form the expected outputs that are compared.
module tb_debounce_multi;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pb_a;
  logic [N-1:0] pb_b;

  logic [N-1:0] a_deb, a_rise, a_fall, a_long, a_held;
  logic [N-1:0] b_deb, b_rise, b_fall, b_long, b_held;

  debounce_multi #(
    .N          (N),
    .CLKFREQ    (1000),
    .DEBOUNCE_MS(4),
    .LONG_MS    (20),
    .ACTIVE_LOW (1'b0)
  ) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb          (pb_a),
    .pb_debounced(a_deb),
    .pb_rise     (a_rise),
    .pb_fall     (a_fall),
    .pb_long     (a_long),
    .pb_held     (a_held)
  );

  debounce_multi #(
    .N          (N),
    .CLKFREQ    (1000),
    .DEBOUNCE_MS(4),
    .LONG_MS    (20),
    .ACTIVE_LOW (1'b1)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb          (pb_b),
    .pb_debounced(b_deb),
    .pb_rise     (b_rise),
    .pb_fall     (b_fall),
    .pb_long     (b_long),
    .pb_held     (b_held)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5*N-1:0] a_all;
  logic [5*N-1:0] b_all;
  assign a_all = {a_deb, a_rise, a_fall, a_long, a_held};
  assign b_all = {b_deb, b_rise, b_fall, b_long, b_held};

  typedef enum int {EvRise, EvFall, EvLong} ev_kind_e;
  typedef struct {
    int unsigned cyc;
    int unsigned ch;
    ev_kind_e    kind;
  } ev_t;

  ev_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] exp_deb, exp_rise, exp_fall, exp_long, exp_held;

  task automatic push_ev(input int unsigned at, input int unsigned ch, input ev_kind_e kind);
    ev_t e;
    e.cyc  = at;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic model_clear();
    sb.delete();
    exp_deb  = '0;
    exp_rise = '0;
    exp_fall = '0;
    exp_long = '0;
    exp_held = '0;
  endtask

  // Pops the events due at 'now' and derives the expected levels from the pulse history:
  // level follows rise/fall, held sets on long and clears the cycle after a fall.
  task automatic model_step(input int unsigned now);
    logic [N-1:0] r, f, l;
    r = '0;
    f = '0;
    l = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == now) begin
        case (sb[i].kind)
          EvRise:  r[sb[i].ch] = 1'b1;
          EvFall:  f[sb[i].ch] = 1'b1;
          default: l[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    exp_held = (exp_held & ~exp_fall) | l;
    exp_deb  = (exp_deb | r) & ~f;
    exp_rise = r;
    exp_fall = f;
    exp_long = l;
  endtask

  task automatic test_reset();
    logic [5*N-1:0] expv;
    rst_n = 1'b0;
    pb_a  = '1;
    pb_b  = '1;
    model_clear();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      model_step(cyc);
      n_vec++;
      if ({a_all, b_all} !== '0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got a=%h b=%h required 0", cyc, a_all, b_all);
      end
    end
    rst_n = 1'b1;
    for (int unsigned ch = 0; ch < N; ch++) push_ev(cyc + 6, ch, EvRise);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      model_step(cyc);
      expv = {exp_deb, exp_rise, exp_fall, exp_long, exp_held};
      n_vec++;
      if (a_all !== expv) begin
        n_err++;
        $display("FAIL reset_release cyc=%0d got=%h required=%h", cyc, a_all, expv);
      end
      if (t == 9) begin
        pb_a = '0;
        for (int unsigned ch = 0; ch < N; ch++) push_ev(cyc + 6, ch, EvFall);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL reset_pending got=%0d events unseen required=0", sb.size());
    end
    model_clear();
  endtask

  task automatic test_bounce();
    logic [5*N-1:0] expv;
    logic           seq [10];
    seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      model_step(cyc);
      expv = {exp_deb, exp_rise, exp_fall, exp_long, exp_held};
      n_vec++;
      if (a_all !== expv) begin
        n_err++;
        $display("FAIL bounce cyc=%0d got=%h required=%h", cyc, a_all, expv);
      end
      if (t < 10) begin
        pb_a[0] = seq[t];
      end else if (t == 10) begin
        pb_a[0] = 1'b1;
        push_ev(cyc + 6, 0, EvRise);
      end else if (t == 20) begin
        pb_a[0] = 1'b0;
        push_ev(cyc + 6, 0, EvFall);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL bounce_pending got=%0d events unseen required=0", sb.size());
    end
    model_clear();
  endtask

  task automatic test_long_press();
    logic [5*N-1:0] expv;
    for (int t = 0; t < 56; t++) begin
      @(negedge clk);
      model_step(cyc);
      expv = {exp_deb, exp_rise, exp_fall, exp_long, exp_held};
      n_vec++;
      if (a_all !== expv) begin
        n_err++;
        $display("FAIL long_press cyc=%0d got=%h required=%h", cyc, a_all, expv);
      end
      if (t == 0) begin
        pb_a[1] = 1'b1;
        push_ev(cyc + 6, 1, EvRise);
        push_ev(cyc + 26, 1, EvLong);
      end else if (t == 40) begin
        pb_a[1] = 1'b0;
        push_ev(cyc + 6, 1, EvFall);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL long_pending got=%0d events unseen required=0", sb.size());
    end
    model_clear();
  endtask

  task automatic test_short_press();
    logic [5*N-1:0] expv;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      model_step(cyc);
      expv = {exp_deb, exp_rise, exp_fall, exp_long, exp_held};
      n_vec++;
      if (a_all !== expv) begin
        n_err++;
        $display("FAIL short_press cyc=%0d got=%h required=%h", cyc, a_all, expv);
      end
      if (t == 0) begin
        pb_a[2] = 1'b1;
        push_ev(cyc + 6, 2, EvRise);
      end else if (t == 15) begin
        pb_a[2] = 1'b0;
        push_ev(cyc + 6, 2, EvFall);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL short_pending got=%0d events unseen required=0", sb.size());
    end
    model_clear();
  endtask

  task automatic test_indep_async_reset();
    logic [5*N-1:0] expv;
    for (int t = 0; t < 17; t++) begin
      @(negedge clk);
      model_step(cyc);
      expv = {exp_deb, exp_rise, exp_fall, exp_long, exp_held};
      n_vec++;
      if (a_all !== expv) begin
        n_err++;
        $display("FAIL indep cyc=%0d got=%h required=%h", cyc, a_all, expv);
      end
      if (t == 0) begin
        pb_a[3] = 1'b1;
        push_ev(cyc + 6, 3, EvRise);
        push_ev(cyc + 26, 3, EvLong);
      end else if (t == 2) begin
        pb_a[0] = 1'b1;
        push_ev(cyc + 6, 0, EvRise);
        push_ev(cyc + 26, 0, EvLong);
      end
    end
    // Assert reset between clock edges; outputs must drop with no edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (a_all !== '0) begin
      n_err++;
      $display("FAIL async_clear got=%h required=0", a_all);
    end
    model_clear();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      n_vec++;
      if (a_all !== '0) begin
        n_err++;
        $display("FAIL async_hold cyc=%0d got=%h required=0", cyc, a_all);
      end
    end
    rst_n = 1'b1;
    push_ev(cyc + 6, 3, EvRise);
    push_ev(cyc + 6, 0, EvRise);
    push_ev(cyc + 26, 3, EvLong);
    push_ev(cyc + 26, 0, EvLong);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      model_step(cyc);
      expv = {exp_deb, exp_rise, exp_fall, exp_long, exp_held};
      n_vec++;
      if (a_all !== expv) begin
        n_err++;
        $display("FAIL requalify cyc=%0d got=%h required=%h", cyc, a_all, expv);
      end
      if (t == 29) begin
        pb_a[3] = 1'b0;
        pb_a[0] = 1'b0;
        push_ev(cyc + 6, 3, EvFall);
        push_ev(cyc + 6, 0, EvFall);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL requalify_pending got=%0d events unseen required=0", sb.size());
    end
    model_clear();
  endtask

  task automatic test_active_low();
    logic [5*N-1:0] expv;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      model_step(cyc);
      expv = {exp_deb, exp_rise, exp_fall, exp_long, exp_held};
      n_vec++;
      if (b_all !== expv) begin
        n_err++;
        $display("FAIL active_low cyc=%0d got=%h required=%h", cyc, b_all, expv);
      end
      if (t == 0) begin
        pb_b[0] = 1'b0;
        push_ev(cyc + 6, 0, EvRise);
        push_ev(cyc + 26, 0, EvLong);
      end else if (t == 30) begin
        pb_b[0] = 1'b1;
        push_ev(cyc + 6, 0, EvFall);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL active_low_pending got=%0d events unseen required=0", sb.size());
    end
    model_clear();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_long_press();
    test_short_press();
    test_indep_async_reset();
    test_active_low();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
